instr_encoder: RTL



---
 rtl/mips_pkg.sv | 31 +++
 rtl/instr_encode_word.sv | 28 ++
 rtl/instr_encoder.sv | 89 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants for the opcode/funct decoder and the program loader.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] K_ADD  = 3'd0;
  localparam logic [2:0] K_SUB  = 3'd1;
  localparam logic [2:0] K_AND  = 3'd2;
  localparam logic [2:0] K_OR   = 3'd3;
  localparam logic [2:0] K_SLT  = 3'd4;
  localparam logic [2:0] K_LW   = 3'd5;
  localparam logic [2:0] K_SW   = 3'd6;
  localparam logic [2:0] K_ADDI = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_encode_word.sv
// Combinational map from a symbolic request to a 32-bit MIPS word (shamt always 0).
module instr_encode_word
  import mips_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    case (kind)
      K_ADD:   word = {OP_RTYPE, rs, rt, rd, 5'h0, F_ADD};
      K_SUB:   word = {OP_RTYPE, rs, rt, rd, 5'h0, F_SUB};
      K_AND:   word = {OP_RTYPE, rs, rt, rd, 5'h0, F_AND};
      K_OR:    word = {OP_RTYPE, rs, rt, rd, 5'h0, F_OR};
      K_SLT:   word = {OP_RTYPE, rs, rt, rd, 5'h0, F_SLT};
      K_LW:    word = {OP_LW,   rs, rt, imm};
      K_SW:    word = {OP_SW,   rs, rt, imm};
      K_ADDI:  word = {OP_ADDI, rs, rt, imm};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes symbolic requests and writes them to instruction memory from address 0.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done
);

  state_t      state_q, state_d;
  logic        last_q;
  logic        xfer;
  logic [31:0] enc_word;

  instr_encode_word u_enc (
    .kind (req_kind),
    .rs   (req_rs),
    .rt   (req_rt),
    .rd   (req_rd),
    .imm  (req_imm),
    .word (enc_word)
  );

  // count never exceeds 2^ADDR_W, so its MSB alone marks full
  assign full = count[ADDR_W];
  assign xfer = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // start outranks everything: it squashes a pending write and refuses a same-cycle request
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    imem_we   = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        req_ready = !full && !start;
        if (xfer) state_d = S_WRITE;
      end
      S_WRITE: begin
        imem_we = !start;
        state_d = last_q ? S_DONE : S_LOAD;
      end
      S_DONE: done = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (start) state_d = S_LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      imem_addr <= '0;
      imem_wd   <= '0;
      last_q    <= 1'b0;
    end else if (start) begin
      count     <= '0;
      imem_addr <= '0;
    end else if (xfer) begin
      imem_wd <= enc_word;
      last_q  <= req_last;
    end else if (state_q == S_WRITE) begin
      count     <= count + 1'b1;
      imem_addr <= imem_addr + 1'b1;
    end
  end

endmodule
